// File: rtl/gray_pkg.sv
// Shared types and helpers for the grey-to-RGB colormap block.
package gray_pkg;

    localparam int unsigned GRAY_W_DEF = 8;
    localparam int unsigned PIX_W_DEF  = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    function automatic pixel_t rep3(input logic [GRAY_W_DEF-1:0] gray);
        pixel_t p;
        p.r = gray;
        p.g = gray;
        p.b = gray;
        return p;
    endfunction

endpackage

// File: rtl/colormap_ram.sv
// Palette storage: one write port and one registered read port with read-enable.
module colormap_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on re, so a stalled read result is held in place
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gray_colormap.sv
// Expands an 8-bit grey stream to 24-bit RGB by replication or palette lookup.
module gray_colormap
    import gray_pkg::*;
#(
    parameter int unsigned GRAY_W        = GRAY_W_DEF,
    parameter int unsigned PIX_W         = PIX_W_DEF,
    parameter bit          INIT_IDENTITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GRAY_W-1:0] gray_in,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              out_last,
    input  logic              lut_en,
    input  logic              lut_we,
    input  logic [GRAY_W-1:0] lut_addr,
    input  logic [PIX_W-1:0]  lut_wdata,
    output logic              busy,
    output logic              frame_done
);

    localparam state_t RST_STATE = INIT_IDENTITY ? ST_INIT : ST_RUN;

    state_t            state_q, state_d;
    logic [GRAY_W-1:0] init_cnt_q, init_cnt_d;
    logic              alive_q;

    logic              s1_valid_q;
    logic [GRAY_W-1:0] s1_gray_q;
    logic              s1_lut_en_q;
    logic              s1_last_q;

    logic              out_valid_q;
    logic [PIX_W-1:0]  pixel_q;
    logic              last_q;
    logic              frame_done_q;

    logic              s2_free;
    logic              s1_adv;
    logic              in_fire;
    logic              out_fire;
    logic              in_ready_c;

    logic              ram_we;
    logic [GRAY_W-1:0] ram_waddr;
    logic [PIX_W-1:0]  ram_wdata;
    logic [PIX_W-1:0]  ram_rdata;
    logic [PIX_W-1:0]  s2_pixel;

    // Handshake. A palette write takes the cycle, so no read can race it.
    always_comb begin
        s2_free    = !out_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_free;
        in_ready_c = alive_q && (state_q == ST_RUN) && !lut_we && (!s1_valid_q || s2_free);
        in_fire    = in_valid && in_ready_c;
        out_fire   = out_valid_q && out_ready;
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + GRAY_W'(1);
            if (init_cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = lut_addr;
        ram_wdata = lut_wdata;
        if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt_q;
            ram_wdata = rep3(init_cnt_q);
        end else if (alive_q && lut_we) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            init_cnt_q <= '0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            alive_q    <= 1'b1;
        end
    end

    colormap_ram #(
        .ADDR_W (GRAY_W),
        .DATA_W (PIX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (in_fire),
        .raddr (gray_in),
        .rdata (ram_rdata)
    );

    // Stage 1: palette read in flight alongside the sample's sideband
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_gray_q   <= '0;
            s1_lut_en_q <= 1'b0;
            s1_last_q   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q  <= 1'b1;
                s1_gray_q   <= gray_in;
                s1_lut_en_q <= lut_en;
                s1_last_q   <= in_last;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        s2_pixel = s1_lut_en_q ? ram_rdata : PIX_W'(rep3(s1_gray_q));
    end

    // Stage 2: output register, frozen while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            pixel_q      <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= out_fire && last_q;
            if (s2_free) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    pixel_q <= s2_pixel;
                    last_q  <= s1_last_q;
                end else begin
                    last_q  <= 1'b0;
                end
            end
        end
    end

    assign in_ready   = in_ready_c;
    assign out_valid  = out_valid_q;
    assign pixel_out  = pixel_q;
    assign out_last   = last_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_INIT);

endmodule

// File: tb/tb_gray_colormap.sv
// Directed bench for gray_colormap: vector table plus multi-cycle corner sequences.
module tb_gray_colormap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  gray_in = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] pixel_out;
    logic        out_last;
    logic        lut_en = 1'b0;
    logic        lut_we = 1'b0;
    logic [7:0]  lut_addr = '0;
    logic [23:0] lut_wdata = '0;
    logic        busy;
    logic        frame_done;

    gray_colormap #(
        .GRAY_W        (8),
        .PIX_W         (24),
        .INIT_IDENTITY (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gray_in    (gray_in),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pixel_out  (pixel_out),
        .out_last   (out_last),
        .lut_en     (lut_en),
        .lut_we     (lut_we),
        .lut_addr   (lut_addr),
        .lut_wdata  (lut_wdata),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [7:0]  g;
        logic        en;
        logic [23:0] exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          run_len = 0;
    int          max_run = 0;
    int          fd_cnt = 0;
    int          ov_cnt = 0;
    bit          rand_ready = 1'b0;
    logic [23:0] model [256];
    logic [23:0] got_pix [$];
    logic        got_last [$];
    logic [23:0] exp_pix [$];
    logic        exp_last [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_pix.push_back(pixel_out);
            got_last.push_back(out_last);
        end
        if (out_valid) begin
            run_len++;
            ov_cnt++;
        end else begin
            run_len = 0;
        end
        if (run_len > max_run) max_run = run_len;
        if (frame_done) fd_cnt++;
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] g, input logic en, input logic last);
        bit ok;
        int t;
        ok = 1'b0;
        t = 0;
        gray_in = g;
        lut_en = en;
        in_last = last;
        in_valid = 1'b1;
        while (!ok && t < 2000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) chk("send_timeout", 32'(t), 32'd0);
    endtask

    task automatic push_exp(input logic [23:0] p, input logic last);
        exp_pix.push_back(p);
        exp_last.push_back(last);
    endtask

    task automatic lut_write(input logic [7:0] addr, input logic [23:0] data);
        lut_we = 1'b1;
        lut_addr = addr;
        lut_wdata = data;
        in_valid = 1'b1;
        gray_in = addr;
        @(negedge clk);
        chk("in_ready_during_write", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        lut_we = 1'b0;
        in_valid = 1'b0;
        model[addr] = data;
    endtask

    task automatic drain_compare(input string tag);
        int t;
        t = 0;
        while (got_pix.size() < exp_pix.size() && t < 8000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, 32'(got_pix.size()), 32'(exp_pix.size()));
        for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
            chk($sformatf("%s_pix[%0d]", tag, i), 32'(got_pix[i]), 32'(exp_pix[i]));
            chk($sformatf("%s_last[%0d]", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
        end
        got_pix.delete();
        got_last.delete();
        exp_pix.delete();
        exp_last.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int cycles, output bit rdy_seen);
        cycles = 0;
        rdy_seen = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (in_ready) rdy_seen = 1'b1;
        end
    endtask

    vec_t vec [10];

    initial begin
        int          bcyc;
        bit          rdy_seen;
        int          t0;
        logic        en;
        logic [23:0] p;

        vec[0] = '{wr: 1'b0, g: 8'h7F, en: 1'b1, exp: 24'h7F7F7F};
        vec[1] = '{wr: 1'b0, g: 8'hFF, en: 1'b1, exp: 24'hFFFFFF};
        vec[2] = '{wr: 1'b1, g: 8'h10, en: 1'b0, exp: 24'hFF0000};
        vec[3] = '{wr: 1'b0, g: 8'h10, en: 1'b1, exp: 24'hFF0000};
        vec[4] = '{wr: 1'b0, g: 8'h11, en: 1'b1, exp: 24'h111111};
        vec[5] = '{wr: 1'b0, g: 8'h10, en: 1'b0, exp: 24'h101010};
        vec[6] = '{wr: 1'b0, g: 8'h11, en: 1'b0, exp: 24'h111111};
        vec[7] = '{wr: 1'b0, g: 8'h20, en: 1'b1, exp: 24'h202020};
        vec[8] = '{wr: 1'b1, g: 8'h20, en: 1'b0, exp: 24'h00FF00};
        vec[9] = '{wr: 1'b0, g: 8'h20, en: 1'b1, exp: 24'h00FF00};
        for (int i = 0; i < 256; i++) model[i] = {3{8'(i)}};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pixel_out", 32'(pixel_out), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;

        wait_init(bcyc, rdy_seen);
        chk("init_busy_cycles", 32'(bcyc), 32'd256);
        chk("init_in_ready_low", 32'(rdy_seen), 32'd0);
        chk("run_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Two-cycle latency on the very first pixel
        gray_in = 8'h00;
        lut_en = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_invalid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        chk("lat_cycle2_pixel", 32'(pixel_out), 32'h000000);
        push_exp(24'h000000, 1'b0);
        @(posedge clk);
        #1;

        // Vector table: identity lookups, palette write, replicate mode, same-address hazard
        foreach (vec[i]) begin
            if (vec[i].wr) begin
                lut_write(vec[i].g, vec[i].exp);
            end else begin
                send(vec[i].g, vec[i].en, 1'b0);
                push_exp(vec[i].exp, 1'b0);
            end
        end
        drain_compare("vec");

        // 1024-pixel ramp against random backpressure
        fd_cnt = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            en = 1'(i % 3 != 0);
            p = en ? model[i % 256] : {3{8'(i)}};
            send(8'(i), en, 1'(i == 1023));
            push_exp(p, 1'(i == 1023));
        end
        drain_compare("ramp");
        rand_ready = 1'b0;
        chk("ramp_frame_done", 32'(fd_cnt), 32'd1);

        // Full throughput, no bubbles
        max_run = 0;
        t0 = cyc;
        for (int i = 0; i < 256; i++) begin
            en = 1'(i % 2);
            p = en ? model[255 - i] : {3{8'(255 - i)}};
            send(8'(255 - i), en, 1'b0);
            push_exp(p, 1'b0);
        end
        chk("thru_accept_cycles", 32'(cyc - t0), 32'd256);
        drain_compare("thru");
        chk("thru_max_run", 32'(max_run), 32'd256);

        // Asynchronous reset with two pixels in flight
        send(8'h30, 1'b1, 1'b0);
        send(8'h31, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_pixel_out", 32'(pixel_out), 32'd0);
        @(posedge clk);
        #1;
        ov_cnt = 0;
        rst_n = 1'b1;
        wait_init(bcyc, rdy_seen);
        chk("reinit_busy_cycles", 32'(bcyc), 32'd256);
        repeat (3) @(negedge clk);
        chk("arst_no_stale_valid", 32'(ov_cnt), 32'd0);
        chk("arst_no_stale_pixels", 32'(got_pix.size()), 32'd0);
        @(posedge clk);
        #1;
        // Palette reinitialised: earlier write to 0x10 is gone
        send(8'h10, 1'b1, 1'b0);
        push_exp(24'h101010, 1'b0);
        drain_compare("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
